// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU datapath.
// Command encoding used by alu_compute and alu_unit.
package alu_pkg;

    localparam int ALU_CMD_W = 4;

    typedef enum logic [ALU_CMD_W-1:0] {
        CMD_AND = 4'h0,
        CMD_OR  = 4'h1,
        CMD_XOR = 4'h2,
        CMD_NOT = 4'h3,
        CMD_ADD = 4'h4,
        CMD_SUB = 4'h5,
        CMD_MUL = 4'h6,
        CMD_SHL = 4'h7,
        CMD_SHR = 4'h8
    } alu_cmd_e;

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU core: next result/overflow from command, a, b.
// Multiply is only built when ALU_MUL_EN is defined.
module alu_compute
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [ALU_CMD_W-1:0] command_i,
    input  logic [SIZE-1:0]      a_i,
    input  logic [SIZE-1:0]      b_i,
    output logic [2*SIZE-1:0]    next_result_o,
    output logic                 next_overflow_o
);

    localparam int W2 = 2 * SIZE;

    logic [SIZE:0]   sum_w;
    logic [SIZE-1:0] diff_w;
    logic            borrow_w;
    logic [W2-1:0]   shl_w;
    logic [W2-1:0]   shl_res;
    logic [SIZE-1:0] shr_w;
    logic [SIZE-1:0] shr_res;
    logic [31:0]     shamt;

    assign shamt    = 32'(b_i);
    assign sum_w    = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w   = a_i - b_i;
    assign borrow_w = (a_i < b_i);

    // Shift in the double-width domain so bits above SIZE are kept.
    assign shl_w   = {{SIZE{1'b0}}, a_i} << b_i;
    assign shl_res = (shamt >= 32'(W2)) ? '0 : shl_w;
    assign shr_w   = a_i >> b_i;
    assign shr_res = (shamt >= 32'(SIZE)) ? '0 : shr_w;

`ifdef ALU_MUL_EN
    logic [W2-1:0] prod_w;

    assign prod_w = {{SIZE{1'b0}}, a_i} * {{SIZE{1'b0}}, b_i};
`endif

    always_comb begin
        next_result_o   = '0;
        next_overflow_o = 1'b0;
        unique case (command_i)
            CMD_AND: begin
                next_result_o = {{SIZE{1'b0}}, a_i & b_i};
            end
            CMD_OR: begin
                next_result_o = {{SIZE{1'b0}}, a_i | b_i};
            end
            CMD_XOR: begin
                next_result_o = {{SIZE{1'b0}}, a_i ^ b_i};
            end
            CMD_NOT: begin
                next_result_o = {{SIZE{1'b0}}, ~a_i};
            end
            CMD_ADD: begin
                next_result_o   = {{(SIZE-1){1'b0}}, sum_w};
                next_overflow_o = sum_w[SIZE];
            end
            CMD_SUB: begin
                next_result_o   = {{SIZE{1'b0}}, diff_w};
                next_overflow_o = borrow_w;
            end
`ifdef ALU_MUL_EN
            CMD_MUL: begin
                next_result_o   = prod_w;
                next_overflow_o = |prod_w[W2-1:SIZE];
            end
`endif
            CMD_SHL: begin
                next_result_o   = shl_res;
                next_overflow_o = |shl_res[W2-1:SIZE];
            end
            CMD_SHR: begin
                next_result_o = {{SIZE{1'b0}}, shr_res};
            end
            default: begin
                next_result_o   = '0;
                next_overflow_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU top: output registers with sync reset and enable.
// Optional multiply is controlled by the ALU_MUL_EN macro.
module alu_unit
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ALU_CMD_W-1:0] command,
    input  logic [SIZE-1:0]      a,
    input  logic [SIZE-1:0]      b,
    output logic                 overflow,
    output logic [2*SIZE-1:0]    result
);

    logic [2*SIZE-1:0] next_result;
    logic              next_overflow;
    logic [2*SIZE-1:0] result_d;
    logic [2*SIZE-1:0] result_q;
    logic              overflow_d;
    logic              overflow_q;

    alu_compute #(
        .SIZE(SIZE)
    ) u_compute (
        .command_i      (command),
        .a_i            (a),
        .b_i            (b),
        .next_result_o  (next_result),
        .next_overflow_o(next_overflow)
    );

    always_comb begin
        result_d   = result_q;
        overflow_d = overflow_q;
        if (enable) begin
            result_d   = next_result;
            overflow_d = next_overflow;
        end
    end

    // Reset wins over enable and drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit at SIZE=4 with a result scoreboard.
// Multiply expectations follow the ALU_MUL_EN macro.
module tb_alu_unit;

    localparam int SIZE = 4;

    typedef struct packed {
        logic [7:0] r;
        logic       o;
    } exp_t;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] r;
        logic       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] command;
    logic [3:0] a;
    logic [3:0] b;
    logic       overflow;
    logic [7:0] result;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    alu_unit #(
        .SIZE(SIZE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .command (command),
        .a       (a),
        .b       (b),
        .overflow(overflow),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic en, input logic [3:0] c,
                         input logic [3:0] aa, input logic [3:0] bb);
        rst     = r;
        enable  = en;
        command = c;
        a       = aa;
        b       = bb;
    endtask

    // Drive one enabled op at negedge and push its expected output.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(1'b0, 1'b1, v.c, v.a, v.b);
        sb.push_back('{r: v.r, o: v.o});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h00 || overflow !== 1'b0)
            $display("FAIL reset: got %h/%b want 00/0", result, overflow);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'h0, 4'hF, 4'hF);
            @(posedge clk);
            #1;
            checks++;
            if (result !== 8'h00 || overflow !== 1'b0)
                $display("FAIL hold%0d: got %h/%b want 00/0", i, result, overflow);
            else passed++;
        end
    endtask

    task automatic test_vectors(input string name, input vec_t vs[$]);
        exp_t e;
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks++;
            if (result !== e.r || overflow !== e.o)
                $display("FAIL %s[%0d] cmd=%h a=%h b=%h: got %h/%b want %h/%b",
                         name, i, vs[i].c, vs[i].a, vs[i].b,
                         result, overflow, e.r, e.o);
            else passed++;
        end
    endtask

    task automatic test_logic;
        vec_t v[$];
        v.push_back('{4'h0, 4'h7, 4'h3, 8'h03, 1'b0});
        v.push_back('{4'h0, 4'hA, 4'h5, 8'h00, 1'b0});
        v.push_back('{4'h1, 4'hA, 4'h5, 8'h0F, 1'b0});
        v.push_back('{4'h1, 4'h7, 4'h3, 8'h07, 1'b0});
        v.push_back('{4'h2, 4'h7, 4'h3, 8'h04, 1'b0});
        v.push_back('{4'h2, 4'hF, 4'hF, 8'h00, 1'b0});
        v.push_back('{4'h3, 4'h1, 4'h9, 8'h0E, 1'b0});
        v.push_back('{4'h3, 4'h7, 4'h0, 8'h08, 1'b0});
        v.push_back('{4'h3, 4'hF, 4'h5, 8'h00, 1'b0});
        test_vectors("logic", v);
    endtask

    task automatic test_arith;
        vec_t v[$];
        v.push_back('{4'h4, 4'h9, 4'h8, 8'h11, 1'b1});
        v.push_back('{4'h4, 4'h3, 4'h4, 8'h07, 1'b0});
        v.push_back('{4'h5, 4'h3, 4'h5, 8'h0E, 1'b1});
        v.push_back('{4'h5, 4'h5, 4'h3, 8'h02, 1'b0});
        test_vectors("arith", v);
    endtask

    task automatic test_mul;
        vec_t v[$];
`ifdef ALU_MUL_EN
        v.push_back('{4'h6, 4'hF, 4'hF, 8'hE1, 1'b1});
        v.push_back('{4'h6, 4'h3, 4'h2, 8'h06, 1'b0});
`else
        v.push_back('{4'h6, 4'hF, 4'hF, 8'h00, 1'b0});
        v.push_back('{4'h6, 4'h3, 4'h2, 8'h00, 1'b0});
`endif
        test_vectors("mul", v);
    endtask

    task automatic test_shift;
        vec_t v[$];
        v.push_back('{4'h7, 4'h9, 4'h2, 8'h24, 1'b1});
        v.push_back('{4'h7, 4'h1, 4'h9, 8'h00, 1'b0});
        v.push_back('{4'h7, 4'hF, 4'h7, 8'h80, 1'b1});
        v.push_back('{4'h7, 4'h3, 4'h1, 8'h06, 1'b0});
        v.push_back('{4'h8, 4'hC, 4'h2, 8'h03, 1'b0});
        v.push_back('{4'h8, 4'hC, 4'h5, 8'h00, 1'b0});
        v.push_back('{4'h8, 4'hC, 4'h4, 8'h00, 1'b0});
        v.push_back('{4'hB, 4'hF, 4'hF, 8'h00, 1'b0});
        v.push_back('{4'hF, 4'h9, 4'h8, 8'h00, 1'b0});
        test_vectors("shift", v);
    endtask

    // Random ops every cycle; result must change only on its own edge.
    task automatic test_back_to_back;
        logic [3:0] c, aa, bb;
        int         r;
        logic       o;
        exp_t       e, prev;
        logic [3:0] ops [4] = '{4'h4, 4'h5, 4'h2, 4'h8};
        prev = '{r: result, o: overflow};
        for (int i = 0; i < 16; i++) begin
            c  = ops[$urandom_range(0, 3)];
            aa = 4'($urandom_range(0, 15));
            bb = 4'($urandom_range(0, 15));
            case (c)
                4'h4: begin r = int'(aa) + int'(bb); o = (r > 15); end
                4'h5: begin r = (int'(aa) - int'(bb) + 16) % 16; o = (aa < bb); end
                4'h2: begin r = int'(aa ^ bb); o = 1'b0; end
                default: begin r = (bb >= 4) ? 0 : (int'(aa) / (1 << bb)); o = 1'b0; end
            endcase
            @(negedge clk);
            checks++;
            if (result !== prev.r || overflow !== prev.o)
                $display("FAIL b2b_hold[%0d]: got %h/%b want %h/%b",
                         i, result, overflow, prev.r, prev.o);
            else passed++;
            drive(1'b0, 1'b1, c, aa, bb);
            sb.push_back('{r: 8'(r), o: o});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (result !== e.r || overflow !== e.o)
                $display("FAIL b2b[%0d] cmd=%h a=%h b=%h: got %h/%b want %h/%b",
                         i, c, aa, bb, result, overflow, e.r, e.o);
            else passed++;
            prev = e;
        end
    endtask

    task automatic test_reset_priority;
        vec_t v[$];
        v.push_back('{4'h4, 4'h9, 4'h8, 8'h11, 1'b1});
        test_vectors("pre_rst", v);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'h4, 4'hF, 4'hF);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h00 || overflow !== 1'b0)
            $display("FAIL rst_prio: got %h/%b want 00/0", result, overflow);
        else passed++;
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h4, 4'hF, 4'hF);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h00 || overflow !== 1'b0)
            $display("FAIL rst_hold: got %h/%b want 00/0", result, overflow);
        else passed++;
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_logic();
        test_arith();
        test_mul();
        test_shift();
        test_back_to_back();
        test_reset_priority();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Parameterised synchronous ALU. Operands a and b are SIZE bits; result is 2*SIZE bits wide so a full product fits.
- A 4-bit command selects a logic, arithmetic or shift operation. The overflow flag marks results that do not fit in SIZE bits.
- Datapath leaf block used by the CPU/controller core. The operation is computed combinationally and the outputs are registered.

Parameters:
- SIZE, default 8, operand width in bits (≥2). The test benches also run SIZE=4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- enable  input  1  when high, sample operands/command and update outputs on the next rising edge
- command  input  4  operation select, see Behaviour
- a  input  SIZE  operand A, unsigned
- b  input  SIZE  operand B, unsigned
- overflow  output  1  result exceeded SIZE bits (meaning depends on the operation), registered
- result  output  2*SIZE  operation result, registered

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on a rising clk edge with rst=1, result=0 and overflow=0. rst has priority over enable. Reset mid-operation discards the pending computation.
- Update: on a rising edge with rst=0 and enable=1, the outputs register the operation of the current a, b and command.
  - Latency: 1 cycle. Outputs are valid immediately after the sampling edge.
  - Back-to-back operations are allowed every cycle.
- Hold: enable=0 (and rst=0) keeps result and overflow at their previous values.
- Command encoding:
  - 0x0 AND: result = zero-extended a & b; overflow=0.
  - 0x1 OR: result = zero-extended a | b; overflow=0.
  - 0x2 XOR: result = zero-extended a ^ b; overflow=0.
  - 0x3 NOT: result = zero-extended ~a, SIZE bits only; upper SIZE bits are 0; b is ignored; overflow=0.
  - 0x4 ADD: result = a + b, zero-extended (SIZE+1 significant bits); overflow = carry out (bit SIZE of the sum).
  - 0x5 SUB: result = (a - b) mod 2^SIZE, zero-extended; overflow = borrow (a < b).
  - 0x6 MUL: result = full unsigned 2*SIZE-bit product; overflow = upper SIZE bits of the product nonzero. Requires the ALU_MUL_EN macro; otherwise the command is reserved.
  - 0x7 SHL: result = zero-extended a shifted left by b in the 2*SIZE domain. If b ≥ 2*SIZE, result=0. overflow = upper SIZE bits of the result nonzero.
  - 0x8 SHR: result = zero-extended a >> b (logical). If b ≥ SIZE, result=0. overflow=0.
  - 0x9–0xF reserved: result=0, overflow=0.
- All operands are unsigned. No X propagation: every command value produces defined outputs.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: command 0x6 performs the multiply as described, with multiplier logic instantiated.
- Undefined: no multiplier is built; command 0x6 behaves as reserved (result=0, overflow=0).

Decomposition:
- Shared package alu_pkg:
  - enum alu_cmd_e (4-bit) with CMD_AND=0, CMD_OR=1, CMD_XOR=2, CMD_NOT=3, CMD_ADD=4, CMD_SUB=5, CMD_MUL=6, CMD_SHL=7, CMD_SHR=8.
  - constant ALU_CMD_W=4.
- One sub-module, alu_compute: purely combinational, parameterised by SIZE, producing next_result/next_overflow from command, a and b.
- Top alu_unit holds only the output registers plus the reset/enable logic.

Test Plan (SIZE=4):
- Reset and hold: rst=1 for 1 edge → result=0x00, overflow=0. Then enable=0 with a=0xF, b=0xF, cmd=AND for 2 edges → outputs stay 0.
- Logic ops, enable=1, one edge each:
  - AND 0x7,0x3 → 0x03; AND 0xA,0x5 → 0x00.
  - OR 0xA,0x5 → 0x0F; OR 0x7,0x3 → 0x07.
  - XOR 0x7,0x3 → 0x04; XOR 0xF,0xF → 0x00.
  - NOT 0x1 → 0x0E; NOT 0x7 → 0x08; NOT 0xF → 0x00.
  - Overflow=0 in all cases.
- Add/sub:
  - ADD 0x9,0x8 → result=0x11, overflow=1; ADD 0x3,0x4 → 0x07, overflow=0.
  - SUB 0x3,0x5 → 0x0E, overflow=1; SUB 0x5,0x3 → 0x02, overflow=0.
- Multiply (ALU_MUL_EN defined):
  - MUL 0xF,0xF → 0xE1, overflow=1; MUL 0x3,0x2 → 0x06, overflow=0.
  - Same stimulus with the macro undefined → 0x00, overflow=0.
- Shifts and reserved:
  - SHL 0x9 by 2 → 0x24, overflow=1; SHL 0x1 by 9 → 0x00.
  - SHR 0xC by 2 → 0x03; SHR 0xC by 5 → 0x00.
  - cmd=0xB → 0x00, overflow=0.
- Timing: change operands every cycle with enable=1 → each result appears exactly one edge after its sampling edge. Assert rst during an ADD cycle → 0x00 on that edge, and rst has priority.
